// File: rtl/det_bcd_converter.sv
// Binary-to-BCD converter for the signed 32-bit determinant: converts |Det| to
// eight decimal digits plus sign and overflow flags over 32 double-dabble cycles.
module det_bcd_converter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Det,
  output logic        Busy,
  output logic        Done,
  output logic        Neg,
  output logic        Ovf,
  output logic [31:0] Bcd,
  output logic [1:0]  dbg_state
);

  // Handshake: Start is a one-cycle request, accepted only while Busy is low;
  // Done stays high with Bcd/Neg/Ovf valid until the next accepted Start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_next_q, neg_next_d;
  logic [31:0] bcd_q, bcd_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;

  logic [39:0] acc_adj;
  logic [39:0] acc_shift;

  // Add-3 correction on every digit that would carry past 9 after doubling.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[38:0], mag_q[31]};
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_next_d = neg_next_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d    = S_CONV;
          neg_next_d = Det[31];
          mag_d      = Det[31] ? (~Det + 32'd1) : Det;
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      S_CONV: begin
        acc_d = acc_shift;
        mag_d = {mag_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          bcd_d   = acc_shift[31:0];
          ovf_d   = (acc_shift[39:32] != 8'd0);
          // The 10-digit accumulator holds any 32-bit magnitude, so zero here means |Det| was zero.
          neg_d   = neg_next_q && (acc_shift != 40'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mag_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_next_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_next_q <= neg_next_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Busy      = (state_q == S_CONV);
  assign Done      = (state_q == S_DONE);
  assign Neg       = neg_q;
  assign Ovf       = ovf_q;
  assign Bcd       = bcd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_det_bcd_converter.sv
// Bench for det_bcd_converter: arithmetic decimal model with 32-cycle latency,
// per-cycle output comparison, and literal checks on the directed cases.
module tb_det_bcd_converter;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] Det;
  logic        Busy;
  logic        Done;
  logic        Neg;
  logic        Ovf;
  logic [31:0] Bcd;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  det_bcd_converter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Det       (Det),
    .Busy      (Busy),
    .Done      (Done),
    .Neg       (Neg),
    .Ovf       (Ovf),
    .Bcd       (Bcd),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal digits by plain division.
  function automatic logic [31:0] to_bcd(input logic [31:0] mag);
    longint unsigned v;
    logic [31:0] r;
    v = mag;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] d);
    return d[31] ? (32'd0 - d) : d;
  endfunction

  logic        m_busy, m_done, m_neg, m_ovf;
  logic [31:0] m_bcd;
  logic        p_neg, p_ovf;
  logic [31:0] p_bcd;
  int          m_left;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_neg <= 1'b0; m_ovf <= 1'b0;
      m_bcd  <= '0;   m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_bcd  <= p_bcd; m_neg <= p_neg; m_ovf <= p_ovf;
      end
    end else if (Start) begin
      p_bcd  <= to_bcd(magnitude(Det));
      p_ovf  <= (longint'(magnitude(Det)) >= 64'd100000000);
      p_neg  <= Det[31] && (magnitude(Det) != 0);
      m_left <= 32;
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end
  end

  // Scoreboard compare: every cycle outside reset
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      check("busy", 32'(Busy), 32'(m_busy));
      check("done", 32'(Done), 32'(m_done));
      check("neg",  32'(Neg),  32'(m_neg));
      check("ovf",  32'(Ovf),  32'(m_ovf));
      check("bcd",  Bcd,       m_bcd);
    end
  end

  // Driver tasks (called at a falling edge)
  task automatic start_conv(input logic [31:0] d);
    Det   = d;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, input bit noise);
    cycles = 0;
    while (Done !== 1'b1 && cycles < 100) begin
      if (noise && $urandom_range(0, 5) == 0) begin
        Start = 1'b1;
        Det   = $urandom;
      end
      @(negedge Clk);
      Start = 1'b0;
      cycles++;
    end
    if (Done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d cycles required=done", cycles);
    end
  endtask

  task automatic expect_result(input string name, input logic [31:0] bcd,
                               input logic neg, input logic ovf);
    check({name, "_bcd"}, Bcd, bcd);
    check({name, "_neg"}, 32'(Neg), 32'(neg));
    check({name, "_ovf"}, 32'(Ovf), 32'(ovf));
  endtask

  logic [31:0] rd;
  int n;

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Det   = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    expect_result("rst", 32'h0, 1'b0, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);

    start_conv(32'd0);
    check("zero_busy_e0", 32'(Busy), 32'd1);
    wait_done(n, 1'b0);
    check("zero_latency", 32'(n), 32'd32);
    expect_result("zero", 32'h0, 1'b0, 1'b0);

    start_conv(32'd1234);
    wait_done(n, 1'b0);
    expect_result("d1234", 32'h00001234, 1'b0, 1'b0);
    start_conv(32'hFFFFFFFB);
    check("restart_done_drop", 32'(Done), 32'd0);
    wait_done(n, 1'b0);
    expect_result("m5", 32'h00000005, 1'b1, 1'b0);

    start_conv(32'd99999999);
    wait_done(n, 1'b0);
    expect_result("max8", 32'h99999999, 1'b0, 1'b0);
    start_conv(32'd100000000);
    wait_done(n, 1'b0);
    expect_result("ovf", 32'h00000000, 1'b0, 1'b1);

    start_conv(32'h80000000);
    wait_done(n, 1'b0);
    expect_result("minint", 32'h47483648, 1'b1, 1'b1);

    start_conv(32'd7);
    repeat (9) @(negedge Clk);
    Start = 1'b1;
    Det   = 32'd9;
    @(negedge Clk);
    Start = 1'b0;
    Det   = 32'd123;
    check("hold_bcd", Bcd, 32'h47483648);
    wait_done(n, 1'b0);
    check("ignore_latency", 32'(n), 32'd22);
    expect_result("ignore", 32'h00000007, 1'b0, 1'b0);

    start_conv(32'd4242);
    repeat (15) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_done", 32'(Done), 32'd0);
    expect_result("arst", 32'h0, 1'b0, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    start_conv(32'd321);
    wait_done(n, 1'b0);
    check("post_rst_latency", 32'(n), 32'd32);
    expect_result("post_rst", 32'h00000321, 1'b0, 1'b0);

    // Randomized back-to-back conversions with ignored Start pulses mid-conversion
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: rd = $urandom;
        1: rd = $urandom_range(0, 999);
        2: rd = 32'd0 - 32'($urandom_range(0, 99999));
        default: rd = 32'($urandom_range(99999990, 100000010));
      endcase
      start_conv(rd);
      wait_done(n, 1'b1);
    end

    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/det_bcd_converter.md
# det_bcd_converter

Sequential binary-to-decimal converter sitting directly downstream of the determinant engine. It takes the signed 32-bit determinant produced when the engine reaches its done state and converts its magnitude to eight BCD digits plus sign and overflow flags using a multi-cycle shift-and-add-3 (double-dabble) loop. The top level drives the eight seven-segment digits from these outputs, so results read in decimal rather than hex.

## Interface
Parameters:
- none; widths are fixed: 32-bit input, 8 output digits, 10 internal digits.

Ports:
- Clk  input  1  system clock (the divided sys_clk at top level); all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- Start  input  1  single-cycle request pulse; samples Det.
- Det  input  32  signed two's-complement determinant.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  level; high while a valid result is held.
- Neg  output  1  sign of the last converted value (1 = negative).
- Ovf  output  1  magnitude ≥ 100,000,000; the result exceeds eight digits.
- Bcd  output  32  eight BCD digits of the magnitude; [31:28] is most significant, [3:0] least significant.

## Operation
- States: IDLE, CONV, DONE (one-hot or binary; encoding free).
- Reset (any time, including mid-CONV): state=IDLE, Busy=0, Done=0, Neg=0, Ovf=0, Bcd=0, iteration counter=0, internal shift registers=0.
- IDLE/DONE + Start=1:
  - Enter CONV.
  - Latch Neg_next = Det[31].
  - Load magnitude register with |Det| as 32-bit unsigned; -2^31 gives 0x80000000 with no saturation.
  - Clear the 40-bit BCD accumulator (10 digits) and the counter.
  - Done drops, Busy rises.
- CONV: each cycle performs one iteration:
  - For each of the 10 accumulator digits, if the digit ≥ 5, add 3.
  - Shift {accumulator, magnitude} left by 1.
  - Increment the counter.
- After the 32nd iteration, enter DONE:
  - Bcd = accumulator[31:0].
  - Ovf = (accumulator[39:32] != 0).
  - Neg = Neg_next, except that Neg is forced to 0 when the magnitude is 0.
  - Done=1, Busy=0.
- Bcd, Neg and Ovf are registered outputs. They hold their previous values throughout CONV and change only on the transition into DONE (or on reset).
- Start while in CONV is ignored: no restart and no effect on the result.
- Start while in DONE restarts the conversion with the new Det; the restart edge clears Done.
- Det is sampled only on the Start edge; later changes to Det have no effect.
- IDLE with no Start: hold all outputs.

## Timing
- Start sampled high at edge E0: at E0, state=CONV and Busy=1.
- Iterations occur at edges E1..E32.
- At E32: state=DONE, Done=1, Busy=0, and Bcd/Neg/Ovf are valid. Latency is 32 cycles from the Start edge to Done.
- Back-to-back operation: a Start in the cycle Done is first high is accepted at the next edge.
- Throughput is one conversion per 33 cycles.
- No combinational path from any input to any output.

## Test plan
- Reset, then Det=0, Start → after 32 cycles Done=1, Bcd=0x00000000, Neg=0, Ovf=0; Busy=1 throughout edges E0..E31.
- Det=32'd1234, Start → Bcd=0x00001234, Neg=0, Ovf=0. Then Det=32'hFFFFFFFB (-5), Start from DONE → Done drops at that edge; after 32 cycles Bcd=0x00000005, Neg=1.
- Det=32'd99999999 → Bcd=0x99999999, Ovf=0. Then Det=32'd100000000 → Bcd=0x00000000, Ovf=1.
- Det=32'h80000000 (-2147483648) → Neg=1, Ovf=1, Bcd=0x47483648.
- Start with Det=7; at E10 pulse Start with Det=9 and change Det → ignored, result Bcd=0x00000007 at E32. Outputs hold the prior result until E32.
- Assert Reset at E15 of a conversion → all outputs 0, state IDLE, asynchronously. A fresh Start after release converts correctly with full 32-cycle latency.
